// File: rtl/gmii_rx_deframer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gmii_rx_deframer: strips preamble/SFD, checks CRC-32 and length, drops FCS
// through a 5-byte delay line and counts good/bad frames.   Rev 1.0
// ----------------------------------------------------------------------------
module gmii_rx_deframer #(
  parameter int MAX_LEN = 402,
  parameter int MIN_LEN = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_dv,
  input  logic        rx_er,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_good,
  output logic        out_bad,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_bad
);

  localparam int               LEN_W       = $clog2(MAX_LEN + 2);
  localparam logic [LEN_W-1:0] MAX_L       = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] MIN_L       = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] DLY_L       = LEN_W'(5);
  localparam logic [LEN_W-1:0] LEN_ONE     = LEN_W'(1);
  localparam logic [31:0]      CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0]      CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0]      CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [7:0]       PRE_BYTE    = 8'h55;
  localparam logic [7:0]       SFD_BYTE    = 8'hD5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             armed_q, armed_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      crc_q, crc_d;
  logic             err_q, err_d;
  logic [4:0][7:0]  dly_q, dly_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_sof_q, out_sof_d;
  logic             out_eof_q, out_eof_d;
  logic             out_good_q, out_good_d;
  logic             out_bad_q, out_bad_d;
  logic [15:0]      ok_cnt_q, ok_cnt_d;
  logic [15:0]      bad_cnt_q, bad_cnt_d;
  logic             frame_good;

  function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Register already includes the received FCS, so a clean frame leaves the residue.
  assign frame_good = (crc_q == CRC_RESIDUE) && !err_q && (len_q >= MIN_L);

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q | ~rx_dv;
    len_d       = len_q;
    crc_d       = crc_q;
    err_d       = err_q;
    dly_d       = dly_q;
    out_data_d  = 8'h00;
    out_valid_d = 1'b0;
    out_sof_d   = 1'b0;
    out_eof_d   = 1'b0;
    out_good_d  = 1'b0;
    out_bad_d   = 1'b0;
    ok_cnt_d    = ok_cnt_q;
    bad_cnt_d   = bad_cnt_q;

    case (state_q)
      IDLE: begin
        if (rx_dv) begin
          state_d = (armed_q && (rx_data == PRE_BYTE)) ? PREAMBLE : DROP;
        end
      end

      PREAMBLE: begin
        if (!rx_dv) begin
          state_d = IDLE;
        end else if (rx_data == SFD_BYTE) begin
          state_d = DATA;
          crc_d   = CRC_INIT;
          len_d   = '0;
          err_d   = 1'b0;
        end else if (rx_data != PRE_BYTE) begin
          state_d = DROP;
        end
      end

      DATA: begin
        if (rx_dv) begin
          if (len_q == MAX_L) begin
            // Overflow: close the frame on the oldest buffered byte, discard the rest.
            out_valid_d = 1'b1;
            out_data_d  = dly_q[4];
            out_sof_d   = (len_q == DLY_L);
            out_eof_d   = 1'b1;
            out_bad_d   = 1'b1;
            bad_cnt_d   = sat_inc(bad_cnt_q);
            state_d     = DROP;
          end else begin
            len_d = len_q + LEN_ONE;
            crc_d = crc_next(crc_q, rx_data);
            dly_d = {dly_q[3:0], rx_data};
            if (rx_er) begin
              err_d = 1'b1;
            end
            if (len_q >= DLY_L) begin
              out_valid_d = 1'b1;
              out_data_d  = dly_q[4];
              out_sof_d   = (len_q == DLY_L);
            end
          end
        end else begin
          state_d = IDLE;
          if (len_q < DLY_L) begin
            bad_cnt_d = sat_inc(bad_cnt_q);
          end else begin
            // Last payload byte; the four bytes still in the line are the FCS.
            out_valid_d = 1'b1;
            out_data_d  = dly_q[4];
            out_sof_d   = (len_q == DLY_L);
            out_eof_d   = 1'b1;
            out_good_d  = frame_good;
            out_bad_d   = !frame_good;
            if (frame_good) begin
              ok_cnt_d  = sat_inc(ok_cnt_q);
            end else begin
              bad_cnt_d = sat_inc(bad_cnt_q);
            end
          end
        end
      end

      DROP: begin
        if (!rx_dv) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      len_q       <= '0;
      crc_q       <= '0;
      err_q       <= 1'b0;
      dly_q       <= '0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_good_q  <= 1'b0;
      out_bad_q   <= 1'b0;
      ok_cnt_q    <= 16'h0000;
      bad_cnt_q   <= 16'h0000;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      len_q       <= len_d;
      crc_q       <= crc_d;
      err_q       <= err_d;
      dly_q       <= dly_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      out_good_q  <= out_good_d;
      out_bad_q   <= out_bad_d;
      ok_cnt_q    <= ok_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_sof    = out_sof_q;
  assign out_eof    = out_eof_q;
  assign out_good   = out_good_q;
  assign out_bad    = out_bad_q;
  assign frames_ok  = ok_cnt_q;
  assign frames_bad = bad_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_gmii_rx_deframer.sv
`default_nettype none
// tb_gmii_rx_deframer: directed + randomized frames, scoreboard of expected
// payload beats (data, flags, arrival cycle) and frame-counter checks.
module tb_gmii_rx_deframer;

  localparam int MAX_LEN = 402;
  localparam int MIN_LEN = 64;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_dv;
  logic        rx_er;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_sof;
  logic        out_eof;
  logic        out_good;
  logic        out_bad;
  logic [15:0] frames_ok;
  logic [15:0] frames_bad;

  gmii_rx_deframer #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx_data    (rx_data),
    .rx_dv      (rx_dv),
    .rx_er      (rx_er),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .out_good   (out_good),
    .out_bad    (out_bad),
    .frames_ok  (frames_ok),
    .frames_bad (frames_bad)
  );

  always #5 clock = ~clock;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0] d;
    logic       sof;
    logic       eof;
    logic       good;
    logic       bad;
    int         cyc;
  } beat_t;

  beat_t sb[$];
  beat_t exp_q[$];
  int    cyc = 0;
  int    chk_cnt = 0;
  int    pass_cnt = 0;
  int    exp_ok = 0;
  int    exp_bad = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard monitor: every beat must arrive exactly in its expected cycle.
  always @(negedge clock) begin
    beat_t e;
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      chk_cnt++;
      $display("FAIL missing_beat: nothing by cycle %0d, expected data %02h at cycle %0d",
               cyc, sb[0].d, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (out_valid) begin
      chk_cnt++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_valid: got data %02h eof %0b at cycle %0d, expected no output",
                 out_data, out_eof, cyc);
      end else begin
        e = sb.pop_front();
        if (out_data === e.d && out_sof === e.sof && out_eof === e.eof &&
            out_good === e.good && out_bad === e.bad && cyc == e.cyc)
          pass_cnt++;
        else
          $display("FAIL beat: got d=%02h sof=%0b eof=%0b good=%0b bad=%0b cyc=%0d, expected d=%02h sof=%0b eof=%0b good=%0b bad=%0b cyc=%0d",
                   out_data, out_sof, out_eof, out_good, out_bad, cyc,
                   e.d, e.sof, e.eof, e.good, e.bad, e.cyc);
      end
    end else begin
      chk_cnt++;
      if ({out_sof, out_eof, out_good, out_bad} === 4'b0000)
        pass_cnt++;
      else
        $display("FAIL idle_flags: got sof/eof/good/bad=%04b without out_valid at cycle %0d, expected 0000",
                 {out_sof, out_eof, out_good, out_bad}, cyc);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    chk_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  task automatic check_counters(input string name);
    check({name, "_frames_ok"}, 32'(frames_ok), 32'(exp_ok));
    check({name, "_frames_bad"}, 32'(frames_bad), 32'(exp_bad));
  endtask

  task automatic step(input logic dv, input logic [7:0] d, input logic er);
    rx_dv   = dv;
    rx_data = d;
    rx_er   = er;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] crc32(input bq_t b, input int n);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[i][k];
        c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB8_8320 : 32'h0);
      end
    end
    return ~c;
  endfunction

  function automatic bq_t with_fcs(input bq_t p);
    bq_t         r;
    logic [31:0] c;
    r = p;
    c = crc32(p, p.size());
    for (int k = 0; k < 4; k++) r.push_back(c[8*k +: 8]);
    return r;
  endfunction

  function automatic bit fcs_ok(input bq_t b);
    int n;
    n = b.size();
    if (n < 4) return 1'b0;
    return crc32(b, n - 4) == {b[n-1], b[n-2], b[n-3], b[n-4]};
  endfunction

  function automatic bq_t rand_payload(input int n);
    bq_t p;
    for (int i = 0; i < n; i++) p.push_back(8'($urandom));
    return p;
  endfunction

  function automatic bq_t ascii_pad(input int n);
    bq_t p;
    for (int i = 0; i < 9; i++) p.push_back(8'h31 + 8'(i));
    while (p.size() < n) p.push_back(8'h00);
    return p;
  endfunction

  // body = all bytes after SFD (FCS included). gap = dv-low cycles after the frame.
  // pre_len = 0 starts with the SFD straight from idle, which must be dropped.
  task automatic send_frame(input bq_t body, input int pre_len, input int er_pos,
                            input int gap, input int abort_at);
    int    len;
    bit    good;
    bit    accepted;
    beat_t b;
    len      = body.size();
    accepted = (pre_len > 0);
    good     = accepted && len >= MIN_LEN && len <= MAX_LEN && fcs_ok(body) &&
               !(er_pos >= 0 && er_pos < len);
    exp_q.delete();
    if (accepted && len > MAX_LEN) begin
      for (int i = 0; i <= MAX_LEN - 5; i++) begin
        b.d = body[i]; b.sof = (i == 0); b.eof = (i == MAX_LEN - 5);
        b.good = 1'b0; b.bad = b.eof; b.cyc = 0;
        exp_q.push_back(b);
      end
    end else if (accepted && len >= 5) begin
      for (int i = 0; i < len - 4; i++) begin
        b.d = body[i]; b.sof = (i == 0); b.eof = (i == len - 5);
        b.good = b.eof && good; b.bad = b.eof && !good; b.cyc = 0;
        exp_q.push_back(b);
      end
    end
    repeat (pre_len) step(1'b1, 8'h55, 1'b0);
    step(1'b1, 8'hD5, 1'b0);
    for (int p = 0; p <= len; p++) begin
      if (p == abort_at) return;
      if (p >= 5 && p - 5 < exp_q.size()) begin
        b = exp_q[p-5];
        b.cyc = cyc + 1;
        sb.push_back(b);
      end
      if (p < len) step(1'b1, body[p], 1'(p == er_pos));
      else         step(1'b0, 8'h00, 1'b0);
    end
    if (accepted) begin
      if (good) exp_ok++;
      else      exp_bad++;
    end
    repeat (gap - 1) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    bq_t f60, body;
    int  n, er, pre, bi;

    reset_n = 1'b0;
    rx_dv   = 1'b0;
    rx_data = 8'h00;
    rx_er   = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_eof", 32'(out_eof), 32'd0);
    check("rst_out_good_bad", 32'({out_good, out_bad}), 32'd0);
    check_counters("rst");
    reset_n = 1'b1;
    repeat (3) step(1'b0, 8'h00, 1'b0);

    f60 = with_fcs(ascii_pad(60));
    send_frame(f60, 7, -1, 2, -1);
    check_counters("good60");

    body = ascii_pad(9);
    body.push_back(8'h26); body.push_back(8'h39); body.push_back(8'hF4); body.push_back(8'hCB);
    send_frame(body, 7, -1, 2, -1);
    check_counters("short13");

    body = f60;
    body[61] = body[61] ^ 8'h04;
    send_frame(body, 7, -1, 2, -1);
    check_counters("fcs_flip");

    send_frame(f60, 7, 30, 2, -1);
    check_counters("rx_er");

    send_frame(with_fcs(rand_payload(496)), 7, -1, 1, -1);
    check_counters("overflow500");
    send_frame(f60, 7, -1, 2, -1);
    check_counters("after_overflow");

    body.delete();
    body.push_back(8'h01); body.push_back(8'h02); body.push_back(8'h03);
    send_frame(body, 7, -1, 1, -1);
    check_counters("runt3");
    send_frame(f60, 7, -1, 1, -1);
    send_frame(f60, 7, -1, 2, -1);
    check_counters("back_to_back");

    send_frame(with_fcs(rand_payload(MAX_LEN - 4)), 3, -1, 1, -1);
    check_counters("len_max");
    send_frame(with_fcs(rand_payload(MAX_LEN - 3)), 3, -1, 1, -1);
    check_counters("len_max_plus1");
    send_frame(with_fcs(rand_payload(MIN_LEN - 5)), 1, -1, 1, -1);
    check_counters("len_min_minus1");
    send_frame(with_fcs(rand_payload(1)), 2, -1, 1, -1);
    check_counters("len5");
    send_frame(with_fcs(rand_payload(0)), 2, -1, 1, -1);
    check_counters("len4_runt");
    send_frame(f60, 0, -1, 2, -1);
    check_counters("no_preamble");

    step(1'b1, 8'h55, 1'b0); step(1'b1, 8'h55, 1'b0); step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h55, 1'b0); step(1'b1, 8'hAA, 1'b0); step(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 8'($urandom), 1'b1);
    step(1'b0, 8'h00, 1'b0);
    check_counters("preamble_abort");

    for (int f = 0; f < 24; f++) begin
      n    = $urandom_range(0, 410);
      body = with_fcs(rand_payload(n));
      if ($urandom_range(0, 3) == 0) begin
        bi = $urandom_range(0, body.size() - 1);
        body[bi] = body[bi] ^ 8'(1 << $urandom_range(0, 7));
      end
      er  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, body.size() - 1) : -1;
      pre = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 7);
      send_frame(body, pre, er, $urandom_range(1, 3), -1);
      check_counters("random");
    end

    send_frame(f60, 7, -1, 1, 20);
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    sb.delete();
    exp_ok  = 0;
    exp_bad = 0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check_counters("midrst");
    repeat (3) step(1'b1, 8'($urandom), 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 30; i++) step(1'b1, (i < 7) ? 8'h55 : ((i == 7) ? 8'hD5 : 8'($urandom)), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check_counters("after_release");
    send_frame(f60, 7, -1, 2, -1);
    check_counters("post_reset_good");

    repeat (10) step(1'b0, 8'h00, 1'b0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    check_counters("final");
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gmii_rx_deframer.md
GMII_RX_DEFRAMER -- requirements
Module: gmii_rx_deframer

Parameters
REQ-001 SHALL have parameter MAX_LEN, default 402, giving the max bytes after SFD, FCS included.
REQ-002 SHALL have parameter MIN_LEN, default 64, giving the min bytes after SFD, FCS included, for a good frame.

Interface
REQ-003 clock  in  1  single clock domain; all logic on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 rx_data  in  8  GMII receive byte.
REQ-006 rx_dv  in  1  GMII data valid.
REQ-007 rx_er  in  1  GMII receive error.
REQ-008 out_data  out  8  payload byte (FCS stripped).
REQ-009 out_valid  out  1  out_data valid this cycle; no backpressure.
REQ-010 out_sof  out  1  first payload byte of frame.
REQ-011 out_eof  out  1  last byte of frame.
REQ-012 out_good  out  1  with out_eof: FCS ok, no rx_er, length in [MIN_LEN, MAX_LEN].
REQ-013 out_bad  out  1  with out_eof: frame failed any check.
REQ-014 frames_ok  out  16  saturating count of good frames.
REQ-015 frames_bad  out  16  saturating count of bad, runt-dropped and overflow frames.

Function
REQ-016 FSM states SHALL be IDLE, PREAMBLE, DATA and DROP.
REQ-017 An armed flag SHALL set on any cycle with rx_dv=0; IDLE SHALL accept a frame start only while armed.
REQ-018 IDLE: armed, rx_dv=1 and rx_data=0x55 -> PREAMBLE; rx_dv=1 otherwise -> DROP.
REQ-019 PREAMBLE: 0x55 -> stay; 0xD5 -> DATA (clear CRC, length, error flag); other byte -> DROP; rx_dv=0 -> IDLE with no count change.
REQ-020 DATA: each rx_dv=1 byte SHALL increment the length, update the CRC and shift into a 5-byte delay line.
REQ-021 DATA: rx_er=1 SHALL set a sticky error flag for the current frame.
REQ-022 CRC SHALL be IEEE 802.3 CRC-32, reflected, LSB first, init 0xFFFFFFFF, computed over all bytes after SFD including FCS.
REQ-023 FCS is good iff the final CRC register equals residue 0xDEBB20E3.
REQ-024 Bytes after SFD are numbered 0..L-1, with L = payload N + 4; the rx_dv-low cycle ending DATA counts as position L.
REQ-025 Payload byte i SHALL appear on the outputs the cycle after the edge sampling position i+5, giving a fixed 5-cycle latency.
REQ-026 out_sof SHALL be 1 with payload byte 0.
REQ-027 out_eof SHALL be 1 with payload byte N-1, which is emitted the cycle after rx_dv is sampled 0.
REQ-028 On the out_eof cycle exactly one of out_good/out_bad SHALL be 1; both SHALL be 0 on all other cycles.
REQ-029 At end of frame the matching counter SHALL increment by 1 and saturate at 0xFFFF.
REQ-030 Runt (L < 5): no out_valid; frames_bad increments; -> IDLE.
REQ-031 L in [5, MIN_LEN): frame is delivered with out_bad=1.
REQ-032 Overflow: when length would reach MAX_LEN+1, the next output cycle SHALL emit the oldest buffered byte with out_eof=1, out_bad=1.
REQ-033 Overflow SHALL then discard the remaining buffer, increment frames_bad and go to DROP.
REQ-034 DROP: ignore input until rx_dv=0, then -> IDLE; no output and no counts.
REQ-035 rx_er outside DATA SHALL be ignored.
REQ-036 out_valid SHALL be 0 on every cycle with no payload byte to emit; output holes inside a frame are impossible.

Reset
REQ-037 reset_n=0 SHALL immediately clear: state=IDLE, armed=0, all out_* = 0, frames_ok = frames_bad = 0, delay line and CRC cleared.
REQ-038 Reset mid-frame SHALL abort the frame without out_eof; a frame in progress at reset release is not accepted (armed=0 until rx_dv=0).

Verification
REQ-039 Frame 7x55, D5, ASCII "123456789" padded with 0x00 to 60 bytes, FCS valid, then dv=0 -> 60 out_valid bytes; sof on 0x31, 5-cycle latency, eof+good on last byte; frames_ok=1.
REQ-040 Payload "123456789" + FCS 26 39 F4 CB -> eof+out_bad (runt, L=13); flip one FCS bit in the 60-byte frame -> out_bad; frames_bad increments each time.
REQ-041 rx_er=1 for one cycle mid-payload of the good frame -> delivered intact, eof+out_bad; frames_bad=1.
REQ-042 Frame of 500 bytes after SFD -> eof+bad after byte index MAX_LEN-5 region; no further out_valid until dv drops; next good frame accepted normally.
REQ-043 3 bytes after SFD then dv=0 -> no out_valid, frames_bad=1; back-to-back good frames with 1 idle cycle between -> both delivered good.
REQ-044 Assert reset_n=0 mid-payload, release with dv still 1 -> no output until dv=0, then next good frame delivered good; counters restart from 0.
